// File: rtl/lut_adder_pipe_if.sv
// Operand, result and table-write bundle for lut_adder_pipe.
// The master side issues operands and table writes; the slave side is the adder.
interface lut_adder_pipe_if #(
  parameter int unsigned WIDTH = 68
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             tbl_we;
  logic [8:0]       tbl_addr;
  logic [4:0]       tbl_wdata;
  logic             tbl_ack;
  logic             mismatch;
  logic [15:0]      err_cnt;

  modport master (
    output in_valid, a, b, cin, mode, out_ready, tbl_we, tbl_addr, tbl_wdata,
    input  in_ready, out_valid, sum, cout, ovf, tbl_ack, mismatch, err_cnt
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready, tbl_we, tbl_addr, tbl_wdata,
    output in_ready, out_valid, sum, cout, ovf, tbl_ack, mismatch, err_cnt
  );
endinterface

// File: rtl/lut_adder_pipe.sv
// Pipelined adder/subtractor whose 4-bit digit sums come from a writable 512x5 lookup table.
// Define LUT_ADDER_CHECK_EN to add a golden-sum checker driving mismatch/err_cnt.
module lut_adder_pipe #(
  parameter int unsigned WIDTH         = 68,
  parameter int unsigned DIG_PER_STAGE = 4
) (
  input logic             clk,
  input logic             rst,
  lut_adder_pipe_if.slave bus
);
  localparam int unsigned NDIG   = WIDTH / 4;
  localparam int unsigned STAGES = (NDIG + DIG_PER_STAGE - 1) / DIG_PER_STAGE;
  localparam int unsigned MSB    = WIDTH - 1;

  if (WIDTH % 4 != 0) begin : g_width_check
    $error("lut_adder_pipe: WIDTH must be a multiple of 4");
  end

  // Operands travel with the beat; res fills in digit by digit as stages complete.
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             c;
  } stage_t;

  stage_t           st_q [STAGES+1];
  stage_t           st_d [STAGES+1];
  logic [4:0]       tbl_q [512];
  logic             tbl_ack_q;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;
  logic             empty;
  logic             tbl_accept;
  logic             accept;
  logic             xfer;
  logic             lc;
  logic [4:0]       lent;
  logic [STAGES:0]  v_all;

  for (genvar k = 0; k <= STAGES; k++) begin : g_valid
    assign v_all[k] = st_q[k].v;
  end

  assign b_eff      = bus.mode ? ~bus.b : bus.b;
  assign c0         = bus.mode ? ~bus.cin : bus.cin;
  assign stall      = st_q[STAGES].v & ~bus.out_ready;
  assign empty      = ~|v_all;
  assign tbl_accept = bus.tbl_we & empty;
  assign accept     = bus.in_valid & bus.in_ready;
  assign xfer       = st_q[STAGES].v & bus.out_ready;

  assign bus.in_ready  = ~stall & ~rst & ~tbl_accept;
  assign bus.out_valid = st_q[STAGES].v;
  assign bus.sum       = st_q[STAGES].res;
  assign bus.cout      = st_q[STAGES].c;
  assign bus.ovf       = (st_q[STAGES].a[MSB] == st_q[STAGES].b[MSB]) &
                         (st_q[STAGES].res[MSB] != st_q[STAGES].a[MSB]);
  assign bus.tbl_ack   = tbl_ack_q;

  // Each entry reloads a_dig + b_dig + c on reset so the table is correct out of reset.
  for (genvar i = 0; i < 512; i++) begin : g_tbl
    localparam logic [8:0] Idx = 9'(i);
    localparam logic [4:0] Def = 5'(Idx[8:5]) + 5'(Idx[4:1]) + 5'(Idx[0]);
    always_ff @(posedge clk) begin
      if (rst) begin
        tbl_q[i] <= Def;
      end else if (tbl_accept && (bus.tbl_addr == Idx)) begin
        tbl_q[i] <= bus.tbl_wdata;
      end
    end
  end

  always_comb begin
    st_d          = st_q;
    st_d[0].v     = accept;
    st_d[0].a     = bus.a;
    st_d[0].b     = b_eff;
    st_d[0].res   = '0;
    st_d[0].c     = c0;
    lc            = 1'b0;
    lent          = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      st_d[k+1] = st_q[k];
      lc        = st_q[k].c;
      for (int unsigned d = 0; d < NDIG; d++) begin
        if (d / DIG_PER_STAGE == k) begin
          lent                       = tbl_q[{st_q[k].a[4*d +: 4], st_q[k].b[4*d +: 4], lc}];
          st_d[k+1].res[4*d +: 4] = lent[3:0];
          lc                         = lent[4];
        end
      end
      st_d[k+1].c = lc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '{default: '0};
      tbl_ack_q <= 1'b0;
    end else begin
      if (!stall) begin
        st_q <= st_d;
      end
      tbl_ack_q <= tbl_accept;
    end
  end

`ifdef LUT_ADDER_CHECK_EN
  logic [WIDTH:0] gold_q [STAGES+1];
  logic [WIDTH:0] gold_d [STAGES+1];
  logic           mismatch_q;
  logic [15:0]    err_cnt_q;
  logic           bad;

  assign bad          = xfer & ({st_q[STAGES].c, st_q[STAGES].res} != gold_q[STAGES]);
  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_cnt_q;

  always_comb begin
    gold_d    = gold_q;
    gold_d[0] = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c0};
    for (int unsigned k = 0; k < STAGES; k++) begin
      gold_d[k+1] = gold_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gold_q     <= '{default: '0};
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (!stall) begin
        gold_q <= gold_d;
      end
      mismatch_q <= bad;
      if (bad && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end
`else
  assign bus.mismatch = 1'b0;
  assign bus.err_cnt  = '0;
`endif

endmodule

// File: tb/tb_lut_adder_pipe.sv
// Directed and random bench for lut_adder_pipe with a queue-based result scoreboard.
module tb_lut_adder_pipe;
  localparam int unsigned W = 68;
`ifdef LUT_ADDER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  exp_t sb[$];

  lut_adder_pipe_if #(.WIDTH(W)) bus ();

  lut_adder_pipe #(.WIDTH(W), .DIG_PER_STAGE(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  // Reference: plain a+b+cin or a-b-cin; cout on subtract is "no borrow".
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic mode);
    logic [W:0] r;
    exp_t       e;
    if (!mode) r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    else       r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    e.sum  = r[W-1:0];
    e.cout = mode ? ~r[W] : r[W];
    e.ovf  = mode ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
                  : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      chk("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum", bus.sum, e.sum);
        chk("cout", bus.cout, e.cout);
        chk("ovf", bus.ovf, e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic mode, input exp_t e);
    int unsigned waited = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.mode     = mode;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    chk("in_ready_wait", waited < 100, 1'b1);
    if (waited < 100) begin
      sb.push_back(e);
      n_in++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic mode);
    send_exp(a, b, cin, mode, model(a, b, cin, mode));
  endtask

  task automatic send_rand();
    logic [95:0] ra;
    logic [95:0] rb;
    ra = {$urandom(), $urandom(), $urandom()};
    rb = {$urandom(), $urandom(), $urandom()};
    send(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    chk("drain", sb.size(), 0);
    cyc();
  endtask

  initial begin
    logic        seen;
    int unsigned n;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;
    rst           = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("in_ready_in_rst", bus.in_ready, 1'b0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, '0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_tbl_ack", bus.tbl_ack, 1'b0);
    chk("rst_mismatch", bus.mismatch, 1'b0);
    chk("rst_err_cnt", bus.err_cnt, 16'h0);
    chk("in_ready_after_rst", bus.in_ready, 1'b1);
    cyc();

    // Carry across 16 digits; also checks the 5-cycle latency.
    send_exp(68'h0_FFFF_FFFF_FFFF_FFFF, 68'h1, 1'b0, 1'b0, mk(68'h1_0000_0000_0000_0000, 1'b0, 1'b0));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen |= bus.out_valid;
      @(posedge clk);
    end
    chk("latency_early", seen, 1'b0);
    @(negedge clk);
    chk("latency_on_time", bus.out_valid, 1'b1);
    cyc();
    drain();

    send_exp(68'h5, 68'h7, 1'b0, 1'b1, mk(68'hF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
    send_exp(68'h7, 68'h5, 1'b0, 1'b1, mk(68'h2, 1'b1, 1'b0));
    send_exp({W{1'b1}}, 68'h1, 1'b0, 1'b0, mk(68'h0, 1'b1, 1'b0));
    drain();

    for (int i = 0; i < 10; i++) send_rand();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_out_valid", bus.out_valid, 1'b1);
      chk("stall_sum_held", bus.sum, sb[0].sum);
      cyc();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_rand();
    drain();
    chk("stream_count", n_out, n_in);

    // Table write requested while a beat is in flight.
    send(68'h2, 68'h3, 1'b0, 1'b0);
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 9'h022;
    bus.tbl_wdata = 5'h03;
    seen          = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      seen |= bus.tbl_ack;
      if (i == 6) chk("in_ready_tbl_accept", bus.in_ready, 1'b0);
      @(posedge clk);
    end
    chk("no_ack_while_busy", seen, 1'b0);
    #1;
    bus.tbl_we = 1'b0;
    @(negedge clk);
    chk("tbl_ack_pulse", bus.tbl_ack, 1'b1);
    cyc();
    @(negedge clk);
    chk("tbl_ack_single", bus.tbl_ack, 1'b0);
    cyc();

    send_exp(68'h1, 68'h1, 1'b0, 1'b0, mk(68'h3, 1'b0, 1'b0));
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tbl_result_seen", bus.out_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("mismatch_pulse", bus.mismatch, ChkEn);
    chk("err_cnt_after_bad", bus.err_cnt, {15'h0, ChkEn});
    cyc();
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("in_ready_mid_rst", bus.in_ready, 1'b0);
    cyc();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= bus.out_valid;
      cyc();
    end
    chk("no_output_after_rst", seen, 1'b0);
    chk("err_cnt_cleared", bus.err_cnt, 16'h0);
    send_exp(68'h1, 68'h1, 1'b0, 1'b0, mk(68'h2, 1'b0, 1'b0));
    drain();

    send_exp(68'h7_FFFF_FFFF_FFFF_FFFF, 68'h1, 1'b0, 1'b0, mk(68'h8_0000_0000_0000_0000, 1'b0, 1'b1));
    drain();
    chk("err_cnt_clean", bus.err_cnt, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
